// File: rtl/serial_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_assembler
// Description : Collects an MSB-first serial bit stream into DATA_WIDTH-bit
//               words with a valid/ready output and a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_assembler #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic [DATA_WIDTH-1:0]         word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_count,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int              c_CW   = $clog2(DATA_WIDTH);
    localparam int              c_SW   = DATA_WIDTH - 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DATA_WIDTH - 1);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_COLLECT = 1'b1;

    logic [0:0]            r_state;
    // Only DATA_WIDTH-1 bits are stored: the completing bit goes straight to word_out.
    logic [c_SW-1:0]       r_shreg;
    logic [c_CW-1:0]       r_bit_count;
    logic [DATA_WIDTH-1:0] r_word_out;
    logic                  r_word_valid;
    logic                  r_overrun;

    logic [DATA_WIDTH-1:0] w_shift;
    logic [c_SW-1:0]       w_first;
    logic                  w_shift_en;
    logic                  w_complete;
    logic                  w_handshake;
    logic                  w_load;
    logic                  w_drop;

    always_comb begin
        w_shift     = {r_shreg, bit_in};
        w_first     = c_SW'(bit_in);
        // frame_start always wins, so a restart can never complete a word.
        w_shift_en  = (r_state == c_COLLECT) && bit_valid && !frame_start;
        w_complete  = w_shift_en && (r_bit_count == c_LAST);
        w_handshake = r_word_valid && word_ready;
        w_load      = w_complete && (!r_word_valid || word_ready);
        w_drop      = w_complete && r_word_valid && !word_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_shreg     <= '0;
            r_bit_count <= '0;
        end else if (frame_start) begin
            r_state     <= c_COLLECT;
            r_shreg     <= bit_valid ? w_first : '0;
            r_bit_count <= c_CW'(bit_valid);
        end else if (w_shift_en) begin
            r_shreg     <= w_shift[c_SW-1:0];
            r_bit_count <= w_complete ? '0 : r_bit_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
        end else if (w_load) begin
            r_word_out   <= w_shift;
            r_word_valid <= 1'b1;
        end else if (w_handshake) begin
            r_word_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign word_out   = r_word_out;
    assign word_valid = r_word_valid;
    assign bit_count  = r_bit_count;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_assembler
// Description : Directed self-checking bench for serial_word_assembler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        word_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic [4:0]  bit_count;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    serial_word_assembler #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .bit_count   (bit_count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "timeout");
    end

    // Sends the low n bits of w MSB-first; frame_start on the first bit if fs.
    task automatic send_bits(input logic [31:0] w, input int n, input bit fs);
        for (int i = n - 1; i >= 0; i--) begin
            frame_start = fs && (i == n - 1);
            bit_valid   = 1'b1;
            bit_in      = w[i];
            @(posedge clk);
            #1;
        end
        frame_start = 1'b0;
        bit_valid   = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #3;
        checks++;
        if (word_out !== 32'h0 || word_valid !== 1'b0 || bit_count !== 5'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h valid=%b cnt=%0d ovr=%b, want 0/0/0/0",
                     word_out, word_valid, bit_count, overrun);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        // Bits without frame_start in IDLE must be ignored.
        send_bits(32'hFFFF_FFFF, 5, 1'b0);
        checks++;
        if (bit_count !== 5'd0) begin
            errors++;
            $display("FAIL idle_ignore: bit_count=%0d want 0", bit_count);
        end
    endtask

    task automatic test_single;
        word_ready = 1'b1;
        send_bits(32'h0000_0001, 32, 1'b1);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h0000_0001 || bit_count !== 5'd0) begin
            errors++;
            $display("FAIL single_word: valid=%b out=%h cnt=%0d want 1/00000001/0",
                     word_valid, word_out, bit_count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: valid=%b want 0 one cycle later", word_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] stream;
        stream     = {32'h8000_0000, 32'hA5A5_A5A5};
        word_ready = 1'b1;
        for (int i = 63; i >= 0; i--) begin
            frame_start = (i == 63);
            bit_valid   = 1'b1;
            bit_in      = stream[i];
            @(posedge clk);
            #1;
            if (i == 32) begin
                checks++;
                if (word_valid !== 1'b1 || word_out !== 32'h8000_0000) begin
                    errors++;
                    $display("FAIL b2b_first: valid=%b out=%h want 1/80000000", word_valid, word_out);
                end
            end
            if (i == 31) begin
                checks++;
                if (word_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: valid=%b want 0", word_valid);
                end
            end
            if (i == 0) begin
                checks++;
                if (word_valid !== 1'b1 || word_out !== 32'hA5A5_A5A5) begin
                    errors++;
                    $display("FAIL b2b_second: valid=%b out=%h want 1/a5a5a5a5", word_valid, word_out);
                end
            end
        end
        frame_start = 1'b0;
        bit_valid   = 1'b0;
    endtask

    task automatic test_overrun;
        @(posedge clk);
        #1 word_ready = 1'b0;
        send_bits(32'h0000_000F, 32, 1'b1);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h0000_000F || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: valid=%b out=%h ovr=%b want 1/0000000f/0",
                     word_valid, word_out, overrun);
        end
        send_bits(32'hFFFF_0000, 32, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h0000_000F || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop: valid=%b out=%h ovr=%b want 1/0000000f/1",
                     word_valid, word_out, overrun);
        end
        overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b valid=%b want 0/1", overrun, word_valid);
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] w;
        w = 32'h3C3C_3C3C;
        for (int i = 31; i >= 0; i--) begin
            bit_valid  = 1'b1;
            bit_in     = w[i];
            word_ready = (i == 0);
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h3C3C_3C3C || overrun !== 1'b0) begin
            errors++;
            $display("FAIL simul_load: valid=%b out=%h ovr=%b want 1/3c3c3c3c/0",
                     word_valid, word_out, overrun);
        end
        @(posedge clk);
        #1;
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_consume: valid=%b want 0", word_valid);
        end
    endtask

    task automatic test_resync;
        word_ready = 1'b1;
        send_bits(32'h0000_034E, 10, 1'b1);
        checks++;
        if (bit_count !== 5'd10) begin
            errors++;
            $display("FAIL resync_partial: bit_count=%0d want 10", bit_count);
        end
        send_bits(32'h1234_5678, 32, 1'b1);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL resync_word: valid=%b out=%h want 1/12345678", word_valid, word_out);
        end
    endtask

    task automatic test_priority;
        word_ready = 1'b1;
        send_bits(32'hFFFF_FFFF, 31, 1'b1);
        checks++;
        if (bit_count !== 5'd31) begin
            errors++;
            $display("FAIL prio_count: bit_count=%0d want 31", bit_count);
        end
        frame_start = 1'b1;
        bit_valid   = 1'b1;
        bit_in      = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        checks++;
        if (word_valid !== 1'b0 || bit_count !== 5'd1) begin
            errors++;
            $display("FAIL prio_restart: valid=%b cnt=%0d want 0/1", word_valid, bit_count);
        end
    endtask

    task automatic test_reset_mid;
        word_ready = 1'b0;
        send_bits(32'h0000_ABCD, 32, 1'b1);
        send_bits(32'h0000_5555, 16, 1'b1);
        checks++;
        if (bit_count !== 5'd16 || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_before: cnt=%0d valid=%b want 16/1", bit_count, word_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (word_out !== 32'h0 || word_valid !== 1'b0 || bit_count !== 5'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out=%h valid=%b cnt=%0d ovr=%b want 0/0/0/0",
                     word_out, word_valid, bit_count, overrun);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        word_ready = 1'b1;
        send_bits(32'hDEAD_BEEF, 32, 1'b0);
        send_bits(32'h0000_00FF, 8, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || bit_count !== 5'd0) begin
            errors++;
            $display("FAIL mid_no_resume: valid=%b cnt=%0d want 0/0", word_valid, bit_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_simultaneous();
        test_resync();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_word_assembler.md
SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 SHALL provide parameter: DATA_WIDTH, default 32, word width in bits (legal range 2..64).
REQ-002 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: frame_start  input  1  marks the first bit of a new word and discards any partial word.
REQ-005 SHALL provide port: bit_in  input  1  serial data bit, MSB of each word first.
REQ-006 SHALL provide port: bit_valid  input  1  bit_in is sampled on this cycle.
REQ-007 SHALL provide port: word_out  output  DATA_WIDTH  assembled word, registered.
REQ-008 SHALL provide port: word_valid  output  1  word_out holds an unconsumed word.
REQ-009 SHALL provide port: word_ready  input  1  downstream accepts word_out when word_valid=1.
REQ-010 SHALL provide port: bit_count  output  $clog2(DATA_WIDTH)  bits collected in the current partial word.
REQ-011 SHALL provide port: overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 SHALL provide port: overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-013 SHALL implement the FSM states IDLE (waiting for frame_start) and COLLECT (shifting bits).
REQ-014 SHALL, in IDLE, ignore bit_valid unless frame_start=1 on the same cycle.
REQ-015 SHALL move IDLE->COLLECT on frame_start=1; if bit_valid=1 on that cycle, bit_in is the word's first bit (bit_count becomes 1), else bit_count becomes 0.
REQ-016 SHALL, in COLLECT on bit_valid=1, shift left: shreg <= {shreg[DATA_WIDTH-2:0], bit_in}, bit_count increments.
REQ-017 SHALL treat the bit sampled when bit_count=DATA_WIDTH-1 as word completion: bit_count wraps to 0 and the FSM stays in COLLECT (back-to-back words need no new frame_start).
REQ-018 SHALL place the first-received bit at word_out[DATA_WIDTH-1] and the last at word_out[0].
REQ-019 SHALL load word_out and set word_valid on the clk edge that samples the completing bit (word visible the cycle after that bit is presented).
REQ-020 SHALL consider a handshake complete on any edge where word_valid=1 and word_ready=1; word_valid clears unless a new word completes on that same edge.
REQ-021 SHALL, on simultaneous completion and handshake, load the new word and keep word_valid=1 (no overrun).
REQ-022 SHALL, on completion while word_valid=1 and word_ready=0, keep old word_out unchanged, drop the new word and set overrun.
REQ-023 SHALL hold word_out stable while word_valid=1 and no handshake occurs.
REQ-024 SHALL, on frame_start=1 in COLLECT, discard the partial word and restart per REQ-015 (bit_count=1 if bit_valid else 0); a pending word_out/word_valid is unaffected.
REQ-025 SHALL give frame_start priority over word completion on the same cycle (no completion occurs).
REQ-026 SHALL clear overrun on overrun_clr=1; if a drop occurs on the same cycle, overrun remains set.
REQ-027 SHALL ignore bit_in when bit_valid=0 (shreg, bit_count unchanged).

Reset
REQ-028 SHALL, while rst=0, force FSM=IDLE, shreg=0, bit_count=0, word_out=0, word_valid=0, overrun=0, independent of clk.
REQ-029 SHALL discard any partial or pending word when rst is asserted mid-operation; after rst rises, a frame_start is required before collection resumes.

Verification
REQ-030 SHALL verify single word (DATA_WIDTH=32): frame_start + 32 bits of 0x00000001 MSB-first, word_ready=1 -> word_out=0x00000001, word_valid high exactly 1 cycle, bit_count back to 0.
REQ-031 SHALL verify back-to-back words: 0x80000000 then 0xA5A5A5A5 with no second frame_start, word_ready=1 -> two words in order, 32 cycles apart with continuous bit_valid.
REQ-032 SHALL verify backpressure/overrun: word_ready=0, send 0x0000000F then 0xFFFF0000 -> word_out stays 0x0000000F, overrun=1; overrun_clr pulse -> overrun=0.
REQ-033 SHALL verify the simultaneous case: word_ready raised on the completing edge of the second word -> word_out=second word, word_valid stays 1, overrun=0.
REQ-034 SHALL verify resync: 10 bits sent, then frame_start + 32 bits of 0x12345678 -> word_out=0x12345678 (partial bits discarded).
REQ-035 SHALL verify reset mid-word: rst low after 16 bits -> all outputs 0 immediately; bits without frame_start after release -> no word_valid.
